// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and op codes for the cache port arbiter
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_SNP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_SNP  = 2'd2
  } owner_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;

  // A CPU request only counts when it carries a real operation.
  function automatic logic cpu_op_valid(logic [1:0] op);
    case (op)
      OP_READ, OP_WRITE, OP_INVAL: cpu_op_valid = 1'b1;
      OP_NONE:                     cpu_op_valid = 1'b0;
      default:                     cpu_op_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cache_arb_watchdog.sv
// rtl/cache_arb_watchdog.sv - ownership timeout counter for the cache port arbiter
module cache_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic own_i,
  input  logic done_i,
  output logic expire_o,
  output logic err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;
  logic          err_q;

  // Fires in the last owned cycle so the grant drops on the same edge that raises the error.
  assign expire_o = own_i && !done_i && (count_q == CW'(TIMEOUT_CYCLES - 1));
  assign err_o    = err_q;

  // Count owned cycles since dp_start; clear whenever ownership ends.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= expire_o;
      if (!own_i || done_i || expire_o) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - CPU/snoop arbiter for the shared cache datapath port (optional watchdog: CACHE_ARB_TIMEOUT_EN)
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int WIDTH_A          = 32,
  parameter int MAX_SNOOP_STREAK = 4,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req_valid,
  input  logic [1:0]         cpu_req_op,
  input  logic [WIDTH_A-1:0] cpu_req_addr,
  output logic               cpu_req_ready,
  input  logic               snp_req_valid,
  input  logic [3:0]         snp_req_type,
  input  logic [WIDTH_A-1:0] snp_req_addr,
  output logic               snp_req_ready,
  output logic               gnt_cpu,
  output logic               gnt_snp,
  output logic [WIDTH_A-1:0] gnt_addr,
  output logic [3:0]         gnt_op,
  output logic               dp_start,
  input  logic               dp_done,
  output logic               arb_err
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_SNOOP_STREAK);

  arb_state_t         state_q;
  logic [3:0]         streak_q;
  logic [3:0]         streak_d;
  logic               gnt_cpu_q;
  logic               gnt_snp_q;
  logic               dp_start_q;
  logic [WIDTH_A-1:0] gnt_addr_q;
  logic [3:0]         gnt_op_q;
  logic               cpu_valid;
  owner_t             winner;
  logic               expire;

  assign cpu_valid = cpu_req_valid && cpu_op_valid(cpu_req_op);

  // Pick the IDLE winner: snoops first unless the CPU has already waited out a full streak.
  always_comb begin
    winner = OWNER_NONE;
    if (state_q == IDLE) begin
      if (snp_req_valid && (!cpu_valid || (streak_q < STREAK_MAX))) begin
        winner = OWNER_SNP;
      end else if (cpu_valid) begin
        winner = OWNER_CPU;
      end
    end
  end

  // Streak counts snoop wins only while the CPU is kept waiting.
  always_comb begin
    streak_d = 4'd0;
    if (cpu_valid) begin
      streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
    end
  end

  // Ready is suppressed during reset so no handshake is seen that the state cannot honour.
  assign cpu_req_ready = rst_n && (winner == OWNER_CPU);
  assign snp_req_ready = rst_n && (winner == OWNER_SNP);

`ifdef CACHE_ARB_TIMEOUT_EN
  cache_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .own_i    (state_q != IDLE),
    .done_i   (dp_done),
    .expire_o (expire),
    .err_o    (arb_err)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign arb_err = 1'b0;
`endif

  // Ownership FSM with registered grant, start pulse and latched request payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      gnt_cpu_q  <= 1'b0;
      gnt_snp_q  <= 1'b0;
      dp_start_q <= 1'b0;
      gnt_addr_q <= '0;
      gnt_op_q   <= 4'd0;
    end else begin
      dp_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winner == OWNER_SNP) begin
            state_q    <= OWN_SNP;
            gnt_snp_q  <= 1'b1;
            dp_start_q <= 1'b1;
            gnt_addr_q <= snp_req_addr;
            gnt_op_q   <= snp_req_type;
            streak_q   <= streak_d;
          end else if (winner == OWNER_CPU) begin
            state_q    <= OWN_CPU;
            gnt_cpu_q  <= 1'b1;
            dp_start_q <= 1'b1;
            gnt_addr_q <= cpu_req_addr;
            gnt_op_q   <= {2'b00, cpu_req_op};
            streak_q   <= 4'd0;
          end
        end
        OWN_CPU, OWN_SNP: begin
          if (dp_done || expire) begin
            state_q   <= IDLE;
            gnt_cpu_q <= 1'b0;
            gnt_snp_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          gnt_cpu_q <= 1'b0;
          gnt_snp_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_cpu  = gnt_cpu_q;
  assign gnt_snp  = gnt_snp_q;
  assign dp_start = dp_start_q;
  assign gnt_addr = gnt_addr_q;
  assign gnt_op   = gnt_op_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - self-checking bench for cache_port_arbiter
module tb_cache_port_arbiter;

  localparam int WA   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req_valid;
  logic [1:0]    cpu_req_op;
  logic [WA-1:0] cpu_req_addr;
  logic          cpu_req_ready;
  logic          snp_req_valid;
  logic [3:0]    snp_req_type;
  logic [WA-1:0] snp_req_addr;
  logic          snp_req_ready;
  logic          gnt_cpu;
  logic          gnt_snp;
  logic [WA-1:0] gnt_addr;
  logic [3:0]    gnt_op;
  logic          dp_start;
  logic          dp_done;
  logic          arb_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_port_arbiter #(
    .WIDTH_A(WA), .MAX_SNOOP_STREAK(MAXS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_op(cpu_req_op), .cpu_req_addr(cpu_req_addr),
    .cpu_req_ready(cpu_req_ready),
    .snp_req_valid(snp_req_valid), .snp_req_type(snp_req_type), .snp_req_addr(snp_req_addr),
    .snp_req_ready(snp_req_ready),
    .gnt_cpu(gnt_cpu), .gnt_snp(gnt_snp), .gnt_addr(gnt_addr), .gnt_op(gnt_op),
    .dp_start(dp_start), .dp_done(dp_done), .arb_err(arb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the port, for how long, and how many snoops in a row starved the CPU.
  int          m_owner = 0;
  bit          m_start = 0;
  bit          m_err   = 0;
  logic [31:0] m_addr  = '0;
  logic [3:0]  m_op    = '0;
  int          m_streak = 0;
  int          m_len    = 0;

  always @(negedge clk) begin
    bit cv, sw, cw;
    cv = cpu_req_valid && (cpu_req_op != 2'b00);
    sw = rst_n && (m_owner == 0) && snp_req_valid && (!cv || (m_streak < MAXS));
    cw = rst_n && (m_owner == 0) && cv && !sw;
    chk("m_gnt_cpu", gnt_cpu, m_owner == 1);
    chk("m_gnt_snp", gnt_snp, m_owner == 2);
    chk("m_dp_start", dp_start, m_start);
    chk("m_gnt_addr", gnt_addr, m_addr);
    chk("m_gnt_op", gnt_op, m_op);
    chk("m_arb_err", arb_err, m_err);
    chk("m_cpu_ready", cpu_req_ready, cw);
    chk("m_snp_ready", snp_req_ready, sw);
    if (!rst_n) begin
      m_owner = 0; m_start = 0; m_err = 0; m_addr = '0; m_op = '0; m_streak = 0; m_len = 0;
    end else begin
      m_start = 0;
      m_err   = 0;
      if (m_owner != 0) begin
        if (dp_done) begin
          m_owner = 0; m_len = 0;
        end else begin
`ifdef CACHE_ARB_TIMEOUT_EN
          if (m_len == TO) begin
            m_owner = 0; m_len = 0; m_err = 1;
          end else begin
            m_len++;
          end
`else
          m_len++;
`endif
        end
      end else if (sw) begin
        m_owner = 2; m_start = 1; m_addr = snp_req_addr; m_op = snp_req_type; m_len = 1;
        m_streak = cv ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else if (cw) begin
        m_owner = 1; m_start = 1; m_addr = cpu_req_addr; m_op = {2'b00, cpu_req_op}; m_len = 1;
        m_streak = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  snp_grants;
    bit  cpu_got;
    bit  done_next;
    bit  found;

    rst_n = 0; cpu_req_valid = 0; cpu_req_op = 0; cpu_req_addr = 0;
    snp_req_valid = 0; snp_req_type = 0; snp_req_addr = 0; dp_done = 0;
    repeat (3) step();
    chk("rst_gnt_cpu", gnt_cpu, 0);
    chk("rst_gnt_snp", gnt_snp, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_gnt_addr", gnt_addr, 0);
    rst_n = 1;
    step();

    // CPU read alone
    cpu_req_valid = 1; cpu_req_op = 2'b01; cpu_req_addr = 32'h0000_1000;
    #1;
    chk("t1_cpu_ready", cpu_req_ready, 1);
    chk("t1_snp_ready", snp_req_ready, 0);
    step();
    chk("t1_gnt_cpu", gnt_cpu, 1);
    chk("t1_dp_start", dp_start, 1);
    chk("t1_gnt_op", gnt_op, 4'h1);
    chk("t1_gnt_addr", gnt_addr, 32'h0000_1000);
    cpu_req_valid = 0; cpu_req_op = 0;
    step();
    chk("t1_start_once", dp_start, 0);
    chk("t1_hold", gnt_cpu, 1);
    step();
    step();
    dp_done = 1;
    step();
    dp_done = 0;
    chk("t1_release", gnt_cpu, 0);

    // op 00 is not a request; dp_done in IDLE is ignored
    cpu_req_valid = 1; cpu_req_op = 2'b00; cpu_req_addr = 32'hDEAD_0000; dp_done = 1;
    #1;
    chk("t_op0_ready", cpu_req_ready, 0);
    step();
    step();
    chk("t_op0_nogrant", gnt_cpu, 0);
    cpu_req_valid = 0; dp_done = 0;
    step();

    // simultaneous arrival, streak 0 -> snoop wins
    cpu_req_valid = 1; cpu_req_op = 2'b10; cpu_req_addr = 32'h0000_3000;
    snp_req_valid = 1; snp_req_type = 4'h7; snp_req_addr = 32'h0000_2000;
    #1;
    chk("t2_snp_ready", snp_req_ready, 1);
    chk("t2_cpu_ready", cpu_req_ready, 0);
    step();
    chk("t2_gnt_snp", gnt_snp, 1);
    chk("t2_gnt_addr", gnt_addr, 32'h0000_2000);
    chk("t2_gnt_op", gnt_op, 4'h7);
    snp_req_valid = 0; dp_done = 1;
    step();
    dp_done = 0;
    #1;
    chk("t2_bubble", gnt_snp | gnt_cpu, 0);
    chk("t2_cpu_next", cpu_req_ready, 1);
    step();
    chk("t2_gnt_cpu", gnt_cpu, 1);
    chk("t2_cpu_addr", gnt_addr, 32'h0000_3000);
    chk("t2_cpu_op", gnt_op, 4'h2);
    cpu_req_valid = 0; dp_done = 1;
    step();
    dp_done = 0;
    step();

    // bounded starvation: snoop held continuously, CPU waiting
    cpu_req_valid = 1; cpu_req_op = 2'b01; cpu_req_addr = 32'h0000_4000;
    snp_req_valid = 1; snp_req_type = 4'h1; snp_req_addr = 32'h0000_5000;
    snp_grants = 0; cpu_got = 0; done_next = 0;
    for (int c = 0; c < 60 && !cpu_got; c++) begin
      step();
      dp_done = done_next;
      done_next = 0;
      if (dp_start) begin
        done_next = 1;
        if (gnt_snp) snp_grants++;
        if (gnt_cpu) begin
          cpu_got = 1; cpu_req_valid = 0; snp_req_valid = 0;
        end
      end
    end
    chk("t3_cpu_granted", cpu_got, 1);
    chk("t3_snp_grants", snp_grants, MAXS);
    chk("t3_model_streak", m_streak, 0);
    step();
    dp_done = 1;
    step();
    dp_done = 0;
    step();

    // reset during OWN_SNP, with a dp_done in the reset cycle
    snp_req_valid = 1; snp_req_type = 4'hB; snp_req_addr = 32'h0000_6000;
    step();
    chk("t4_gnt_snp", gnt_snp, 1);
    snp_req_valid = 0;
    step();
    rst_n = 0; dp_done = 1;
    #1;
    chk("t4_rst_ready", snp_req_ready | cpu_req_ready, 0);
    step();
    rst_n = 1; dp_done = 0;
    chk("t4_gnt_snp_clr", gnt_snp, 0);
    chk("t4_gnt_cpu_clr", gnt_cpu, 0);
    chk("t4_dp_start_clr", dp_start, 0);
    chk("t4_addr_clr", gnt_addr, 0);
    chk("t4_op_clr", gnt_op, 0);
    chk("t4_err_clr", arb_err, 0);
    step();
    chk("t4_still_idle", gnt_snp | gnt_cpu, 0);

    // dp_done in the dp_start cycle
    cpu_req_valid = 1; cpu_req_op = 2'b10; cpu_req_addr = 32'h0000_7000;
    step();
    chk("t5_c1_gnt", gnt_cpu, 1);
    chk("t5_c1_start", dp_start, 1);
    dp_done = 1; cpu_req_op = 2'b11; cpu_req_addr = 32'h0000_7100;
    step();
    dp_done = 0;
    #1;
    chk("t5_c2_bubble", gnt_cpu, 0);
    chk("t5_c2_ready", cpu_req_ready, 1);
    step();
    chk("t5_c3_gnt", gnt_cpu, 1);
    chk("t5_c3_start", dp_start, 1);
    chk("t5_c3_op", gnt_op, 4'h3);
    chk("t5_c3_addr", gnt_addr, 32'h0000_7100);
    cpu_req_valid = 0; dp_done = 1;
    step();
    dp_done = 0;
    step();

    // watchdog behaviour with no dp_done
    cpu_req_valid = 1; cpu_req_op = 2'b01; cpu_req_addr = 32'h0000_8000;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (dp_start) found = 1;
    end
    chk("t6_started", found, 1);
    cpu_req_valid = 0;
`ifdef CACHE_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO + 1; k++) begin
      step();
      if (k < TO) begin
        chk("t6_hold", gnt_cpu, 1);
        chk("t6_no_err", arb_err, 0);
      end else if (k == TO) begin
        chk("t6_err_pulse", arb_err, 1);
        chk("t6_dropped", gnt_cpu, 0);
      end else begin
        chk("t6_err_once", arb_err, 0);
      end
    end
`else
    for (int k = 1; k <= 100; k++) begin
      step();
      chk("t6_held", gnt_cpu, 1);
      chk("t6_err_zero", arb_err, 0);
    end
    dp_done = 1;
    step();
    dp_done = 0;
    chk("t6_release", gnt_cpu, 0);
`endif
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single cache datapath port (tag/state lookup, data array) between two requesters: the CPU request path and the ACE snoop path (AC channel).
- Sits between the CPU/AC interfaces and the cache controller/datapath.
- Grants one owner at a time and issues a start pulse to the datapath.
- Holds ownership until the datapath signals completion.
- Snoops have priority, with a bounded-starvation guarantee for the CPU.

Parameters:
- WIDTH_A, 32, address width.
- MAX_SNOOP_STREAK, 4, max consecutive snoop grants while the CPU is waiting; range 1..15.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with CACHE_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cpu_req_valid  in  1  CPU request pending
- cpu_req_op  in  2  01 read, 10 write, 11 invalidate; 00 treated as no request
- cpu_req_addr  in  WIDTH_A  CPU address
- cpu_req_ready  out  1  CPU request accepted this cycle
- snp_req_valid  in  1  snoop pending (AC_VALID)
- snp_req_type  in  4  AC_SNOOP code
- snp_req_addr  in  WIDTH_A  snoop address
- snp_req_ready  out  1  snoop accepted (drives AC_READY)
- gnt_cpu  out  1  CPU owns the datapath
- gnt_snp  out  1  snoop owns the datapath
- gnt_addr  out  WIDTH_A  latched address of the current owner
- gnt_op  out  4  latched op: CPU op zero-extended, or snoop type
- dp_start  out  1  one-cycle pulse, first cycle of ownership
- dp_done  in  1  datapath finished the current access
- arb_err  out  1  watchdog timeout pulse (tied 0 without the macro)

Behaviour:
- Reset: every output is 0; state IDLE; streak=0; latches cleared.
  - Reset is synchronous and takes effect even mid-ownership.
  - A dp_done arriving in the same cycle as reset is ignored.
- A CPU request is valid when cpu_req_valid=1 and cpu_req_op!=00.
- FSM has three states: IDLE, OWN_CPU, OWN_SNP.
- In IDLE the winner is chosen combinationally:
  - snoop wins if snp_req_valid and (CPU not valid or streak<MAX_SNOOP_STREAK);
  - otherwise the CPU wins if valid.
- Only the winner's ready is asserted, combinationally in IDLE. A handshake is valid&ready. The loser's ready stays 0; requesters must hold valid and payload until ready.
- On handshake at edge N:
  - gnt_addr and gnt_op are latched;
  - the state moves to OWN_x;
  - in cycle N+1 the matching gnt_x=1 and dp_start=1 (registered, exactly one cycle).
- In OWN_x:
  - ready outputs stay 0 and gnt_x stays high;
  - dp_done is accepted in any cycle, including the dp_start cycle.
- On dp_done the state returns to IDLE at the next edge and gnt_x drops. There is one mandatory IDLE bubble between owners; no back-to-back grants.
- dp_done in IDLE is ignored.
- Streak update, applied at the handshake edge:
  - snoop grant with CPU valid: streak+1, saturating at MAX_SNOOP_STREAK;
  - snoop grant without CPU valid: streak=0;
  - CPU grant: streak=0.
- Simultaneous arrival with streak<MAX: snoop wins.
- Worst-case CPU wait: MAX_SNOOP_STREAK snoop ownerships, plus bubbles.
- gnt_cpu and gnt_snp are never both 1 (one-hot-or-zero).

Optional Feature:
- CACHE_ARB_TIMEOUT_EN defined:
  - a counter starts at dp_start and increments each OWN cycle;
  - if it reaches TIMEOUT_CYCLES without dp_done, arb_err pulses for one cycle, the grant is dropped and the state returns to IDLE;
  - streak is unchanged;
  - the counter clears on dp_done, timeout, or reset.
- Not defined: no counter, arb_err is constant 0, and ownership can be held indefinitely.

Decomposition:
- Package cache_arb_pkg holds:
  - arb_state_t enum {IDLE, OWN_CPU, OWN_SNP};
  - CPU op localparams OP_NONE/OP_READ/OP_WRITE/OP_INVAL;
  - the owner_t enum.
- The streak logic stays inline.
- One natural sub-module, cache_arb_watchdog, holds the timeout counter. It is instantiated only under CACHE_ARB_TIMEOUT_EN.

Test Plan:
- CPU read 0x0000_1000 alone → cpu_req_ready=1 in the same cycle; next cycle gnt_cpu=1, dp_start=1, gnt_op=4'h1; dp_done 3 cycles later → gnt_cpu=0 on the following cycle.
- CPU and snoop (type 4'h7, addr 0x2000) valid together, streak=0 → snp_req_ready=1, cpu_req_ready=0; gnt_snp then gnt_addr=0x2000.
- Snoop held valid continuously with CPU valid, MAX_SNOOP_STREAK=4, dp_done one cycle after each start → exactly 4 snoop grants, then a CPU grant, then streak back to 0.
- rst_n low for one cycle during OWN_SNP → next cycle all outputs 0 and state IDLE; dp_done in that reset cycle produces no effect.
- dp_done asserted in the dp_start cycle → ownership lasts 1 cycle, IDLE bubble 1 cycle, next grant on cycle 3.
- With CACHE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no dp_done → arb_err pulses once, 8 cycles after dp_start, and the grant drops; without the macro, arb_err stays 0 and the grant is held for 100 cycles.
